// File: rtl/model_bus_collector.sv
`default_nettype none
// ============================================================================
// Module   : model_bus_collector
// Purpose  : Captures the two 5-bit result buses of the `model` cell under a
//            valid/ready handshake, normalises them into one 10-bit word
//            (highest numeric bit index at the MSB of each half), buffers the
//            words in a small FIFO and presents them downstream under a second
//            valid/ready handshake. Refused captures (buffer full) are counted
//            in a saturating drop counter.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            in_valid/in_ready    - upstream handshake
//            o0 [2:-2], o1 [-2:2] - model result buses
//            out_valid/out_ready  - downstream handshake
//            out_data [9:0]       - FIFO head word, 0 when empty
//            level                - current occupancy
//            drop_cnt             - refused-capture count, saturating
// Revision : 1.0 - initial release
// ============================================================================
module model_bus_collector #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:-2]              o0,
  input  logic [-2:2]              o1,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [9:0]               out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] c_FULL = LVL_W'(DEPTH);

  logic [9:0]        r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [DROP_W-1:0] r_drop;

  logic [9:0] w_word;
  logic       w_push;
  logic       w_pop;
  logic       w_drop;

  // Both halves stored with the highest numeric index at the MSB; for o1
  // this reverses its declared order.
  assign w_word = {o0[2], o0[1], o0[0], o0[-1], o0[-2],
                   o1[2], o1[1], o1[0], o1[-1], o1[-2]};

  // Handshake outputs depend on registered occupancy only; in_ready does not
  // look at out_ready, so a pop while full never frees a slot that cycle.
  assign in_ready  = (r_level != c_FULL);
  assign out_valid = (r_level != '0);
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : 10'h000;
  assign level     = r_level;
  assign drop_cnt  = r_drop;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;
  assign w_drop = in_valid && !in_ready;

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_drop   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop && (r_drop != {DROP_W{1'b1}})) begin
        r_drop <= r_drop + DROP_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_model_bus_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_model_bus_collector
// Purpose  : Self-checking bench for model_bus_collector. A queue-based model
//            of the buffer tracks expected occupancy, head word and drop
//            count; directed sequences are followed by a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_model_bus_collector;

  localparam int DEPTH  = 4;
  localparam int DROP_W = 8;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [2:-2]            o0;
  logic [-2:2]            o1;
  logic                   out_valid;
  logic                   out_ready;
  logic [9:0]             out_data;
  logic [$clog2(DEPTH):0] level;
  logic [DROP_W-1:0]      drop_cnt;

  model_bus_collector #(
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .o0        (o0),
    .o1        (o1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a queue of words plus a drop count.
  logic [9:0] mq[$];
  int         mdrop;

  function automatic logic [4:0] rev5(input logic [4:0] v);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = v[4-i];
    return r;
  endfunction

  // Drive one cycle, advance the model at the edge, compare at the negedge.
  task automatic step(input logic r, input logic iv, input logic [4:0] a,
                      input logic [4:0] b, input logic ordy);
    logic       full;
    logic       canpop;
    logic [9:0] w;
    rst = r; in_valid = iv; o0 = a; o1 = b; out_ready = ordy;
    @(posedge clk);
    if (r) begin
      mq.delete();
      mdrop = 0;
    end else begin
      full   = (mq.size() == DEPTH);
      canpop = (mq.size() != 0) && ordy;
      // o1 bit at index -2 lands on the packed MSB; the word wants index 2 there.
      w      = {a, rev5(b)};
      if (canpop) void'(mq.pop_front());
      if (iv && !full) mq.push_back(w);
      if (iv && full && mdrop < DROP_MAX) mdrop++;
    end
    @(negedge clk);
    check("level",     32'(level),     32'(mq.size()));
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("in_ready",  32'(in_ready),  32'(mq.size() != DEPTH));
    check("out_data",  32'(out_data),  (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
    check("drop_cnt",  32'(drop_cnt),  32'(mdrop));
  endtask

  task automatic push_w(input logic [9:0] w, input logic ordy);
    step(1'b0, 1'b1, w[9:5], rev5(w[4:0]), ordy);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 5'd0, 5'd0, ordy);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; o0 = '0; o1 = '0; out_ready = 1'b0;
    mdrop = 0;
    @(negedge clk);

    // Reset and bit order
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
    check("rst_level",     32'(level),     32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'h0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_drop",      32'(drop_cnt),  32'd0);
    step(1'b0, 1'b1, 5'b10110, 5'b10011, 1'b0);
    check("bitorder_valid", 32'(out_valid), 32'd1);
    check("bitorder_data",  32'(out_data),  32'(10'b10110_11001));
    idle(1'b1);

    // Fill and full
    for (int i = 1; i <= 4; i++) push_w(10'(i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5'($urandom), 5'($urandom), 1'b0);
    check("full_level", 32'(level),    32'd4);
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_drop",  32'(drop_cnt), 32'd3);
    check("full_head",  32'(out_data), 32'h001);

    // Drain with wrap-around
    for (int i = 0; i < 4; i++) begin
      check("drain_head", 32'(out_data), 32'(1 + i));
      idle(1'b1);
    end
    for (int i = 0; i < 10; i++) begin
      push_w(10'(10'h100 + i), 1'b1);
      check("wrap_head", 32'(out_data), 32'(10'h100 + i));
    end
    idle(1'b1);
    check("empty_level", 32'(level),    32'd0);
    check("empty_data",  32'(out_data), 32'h0);

    // Simultaneous push and pop
    push_w(10'h200, 1'b0);
    push_w(10'h201, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("pp_head", 32'(out_data), 32'(10'h200 + i));
      push_w(10'(10'h202 + i), 1'b1);
      check("pp_level", 32'(level), 32'd2);
    end
    push_w(10'h207, 1'b0);
    push_w(10'h208, 1'b0);
    check("pp_full", 32'(level), 32'd4);
    push_w(10'h3FF, 1'b1);
    check("fullpp_level", 32'(level),    32'd3);
    check("fullpp_drop",  32'(drop_cnt), 32'd4);
    check("fullpp_head",  32'(out_data), 32'h206);

    // Drop-counter saturation
    push_w(10'h209, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 5'($urandom), 5'($urandom), 1'b0);
    check("sat_drop", 32'(drop_cnt), 32'hFF);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 5'($urandom), 5'($urandom), 1'b0);
    check("sat_hold", 32'(drop_cnt), 32'hFF);

    // Reset mid-stream
    idle(1'b1);
    check("mid_pre_level", 32'(level), 32'd3);
    step(1'b1, 1'b1, 5'b10101, 5'b01010, 1'b1);
    check("mid_level", 32'(level),     32'd0);
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_drop",  32'(drop_cnt),  32'd0);
    push_w(10'h155, 1'b0);
    check("mid_next", 32'(out_data), 32'h155);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) == 0), 1'($urandom), 5'($urandom),
           5'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/model_bus_collector.md
# model_bus_collector

Downstream consumer of the `model` cell's two 5-bit result buses: `o0` declared `[2:-2]` and `o1` declared `[-2:2]`. It samples both buses under a valid/ready handshake and normalises them into one 10-bit word with a fixed bit order. The words are buffered in a small FIFO and presented to the next stage under a second valid/ready handshake. It also counts attempted captures that were refused because the buffer was full.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, legal range 2..16.
- `DROP_W`, default 8: width of the saturating drop counter.

Ports:
- `clk`  input  1  — single clock; all state updates on its rising edge.
- `rst`  input  1  — synchronous, active-high reset.
- `in_valid`  input  1  — producer has a `model` result on `o0`/`o1` this cycle.
- `in_ready`  output  1  — collector can accept a word this cycle.
- `o0`  input  [2:-2]  — `model` output bus 0; MSB index 2.
- `o1`  input  [-2:2]  — `model` output bus 1; MSB index -2.
- `out_valid`  output  1  — `out_data` holds the FIFO head.
- `out_ready`  input  1  — consumer accepts the head this cycle.
- `out_data`  output  10  — normalised head word.
- `level`  output  $clog2(DEPTH)+1  — current occupancy.
- `drop_cnt`  output  DROP_W  — count of refused captures, saturating.

## Operation
- Normalisation, applied at capture:
  - `word[9:5] = {o0[2], o0[1], o0[0], o0[-1], o0[-2]}`.
  - `word[4:0] = {o1[2], o1[1], o1[0], o1[-1], o1[-2]}`.
  - Both halves are therefore stored with the highest numeric index at the MSB, regardless of declared direction. `o1` is bit-reversed relative to its declared order; `o0` is not.
- Push: occurs when `in_valid && in_ready`. `word` is written at the write pointer, and the write pointer advances modulo `DEPTH`.
- Pop: occurs when `out_valid && out_ready`. The read pointer advances modulo `DEPTH`.
- `in_ready = (level != DEPTH)`.
  - There is no same-cycle bypass when full: a pop while full does not allow a push in that same cycle.
- `out_valid = (level != 0)`.
- `out_data` = entry at the read pointer when `out_valid`; forced to 10'h000 when empty.
- `level` update, by event in a cycle:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged. This is legal for any `level` in 1..DEPTH−1.
  - neither: unchanged.
- Drop: `in_valid && !in_ready` increments `drop_cnt`.
  - `drop_cnt` saturates at all-ones; it never wraps.
  - Dropped data is discarded, with no other side effect.
- Pointer wrap: pointers are `$clog2(DEPTH)` bits and wrap naturally. `level` is tracked separately, so full and empty are unambiguous.
- Behaviour is defined only for known (0/1) inputs. An unconnected upstream bit is driven 0 by convention.
- No FSM beyond the FIFO occupancy. The implicit states are EMPTY (`level`=0), PARTIAL and FULL (`level`=DEPTH), with transitions purely as given by the `level` rules above.

## Timing
- Reset, applied at the first rising `clk` with `rst`=1:
  - pointers = 0, `level` = 0, `drop_cnt` = 0.
  - `out_valid` = 0, `out_data` = 10'h000, `in_ready` = 1.
  - FIFO storage is not cleared.
- Reset mid-operation:
  - All buffered words are lost.
  - Any push or pop presented in the reset cycle is ignored.
  - Normal operation resumes on the cycle after `rst` falls.
- Latency: a word pushed at edge N appears on `out_data` with `out_valid`=1 after edge N, i.e. in cycle N+1, provided the FIFO was empty.
- Throughput: one push and one pop per cycle are sustainable indefinitely while 0 < `level` < DEPTH.
- `in_ready`, `out_valid`, `level` and `out_data` are functions of registered state only. None of them combinationally depends on `in_valid` or `out_ready`.

## Test plan
- Reset and bit order:
  - Stimulus: assert `rst` for 2 cycles, check reset values, then push `o0`=5'b10110 (`o0[2]`=1), `o1` = {`o1[-2]`..`o1[2]`} = 5'b10011.
  - Required: next cycle `out_valid`=1 and `out_data`=10'b10110_11001.
- Fill and full:
  - Stimulus: with `out_ready`=0, push 4 words 10'h001..10'h004, then hold `in_valid`=1 for 3 more cycles.
  - Required: `level`=4, `in_ready`=0, `drop_cnt`=3, head=10'h001.
- Drain with wrap-around:
  - Stimulus: from full, pop 4, then push/pop 10 further words.
  - Required: output order is exactly the push order, and `level` returns to 0 with `out_data`=10'h000.
- Simultaneous push and pop:
  - Stimulus: at `level`=2, assert push and pop together for 5 cycles.
  - Required: `level` stays 2 and output order is preserved. At `level`=4 with push+pop, only the pop occurs and `drop_cnt` increments.
- Drop-counter saturation:
  - Stimulus: with `DROP_W`=8, hold the FIFO full with `in_valid`=1 for 300 cycles.
  - Required: `drop_cnt`=8'hFF, and it stays 8'hFF.
- Reset mid-stream:
  - Stimulus: at `level`=3, assert `rst` for 1 cycle with push and pop also asserted.
  - Required: next cycle `level`=0, `out_valid`=0, `drop_cnt`=0, and the next push is the next word output.
